demo_slave_responder: RTL
=========================

Name: demo_slave_responder

Overview:
- Bus-side responder for the demo system: the target-end counterpart of the demo master driver.
- Sits on the slave port of the system bus and services single-beat read/write requests against a local synchronous-read memory.
- Exposes a push-button readback port so board LEDs can show any stored byte, plus a write counter for on-board visibility.

Parameters:
ADDR_WIDTH, 16, width of bus address presented on s_addr
DATA_WIDTH, 8, width of data bus and memory word
MEM_ADDR_WIDTH, 5, local memory depth = 2**MEM_ADDR_WIDTH words
READ_LATENCY, 2, cycles from read accept to s_rvalid (min 1, max 3)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  request strobe, one cycle
s_mode  in  1  0 read, 1 write; sampled with s_valid
s_addr  in  ADDR_WIDTH  request address; only [MEM_ADDR_WIDTH-1:0] used
s_wdata  in  DATA_WIDTH  write data; sampled with s_valid
s_rdata  out  DATA_WIDTH  read data; valid only while s_rvalid
s_rvalid  out  1  one-cycle read-data strobe
s_ready  out  1  high when a request can be accepted
disp_btn  in  1  active-low push button (already synchronised)
disp_addr  in  MEM_ADDR_WIDTH  readback address, sampled on button edge
disp_data  out  DATA_WIDTH  last readback value, held
wr_count  out  8  number of accepted writes, modulo 256

Behaviour:
- Only one clock domain and one reset: clk; rst synchronous active-high.
- Reset values: s_ready 1, s_rvalid 0, s_rdata 0, disp_data 0, wr_count 0, state IDLE, button-previous flag 1, display-pending 0.
- Memory contents are not cleared by reset.
- Accept rule: request accepted on the cycle where s_valid && s_ready.
  - s_valid while s_ready=0 is ignored: no queueing, no error.
- States: IDLE, WRITE, READ, RESP, DISP.
- IDLE:
  - s_ready=1.
  - Accepted write goes to WRITE: memory written at low address bits with s_wdata on the next edge; wr_count increments.
  - Accepted read goes to READ: address registered, latency counter cleared.
  - Else, if display-pending, go to DISP.
- WRITE: s_ready=0 for exactly 1 cycle, then IDLE. Back-to-back writes accept every 2 cycles.
- READ:
  - s_ready=0; counter increments each cycle.
  - When counter == READ_LATENCY-1, go to RESP with memory output captured into s_rdata.
- RESP:
  - s_rvalid=1 for exactly 1 cycle, s_ready=0, then IDLE.
  - Total read latency: s_rvalid rises READ_LATENCY+1 edges after accept.
  - s_rdata holds its value after s_rvalid falls.
- Button edge: falling edge = prev && !disp_btn, prev registered each cycle.
  - The edge sets display-pending and latches disp_addr.
  - An edge while display-pending is already set relatches the address.
- DISP:
  - Uses the same memory port and the same READ_LATENCY wait.
  - Then updates disp_data, clears display-pending, returns to IDLE.
  - s_ready=0 throughout DISP.
- Priority: an accepted bus request in IDLE beats a pending display read; display is serviced on the first IDLE cycle with no s_valid.
- Read-after-write to the same address returns the new data (write completes in WRITE before any READ can be accepted).
- Address wrap: s_addr bits above MEM_ADDR_WIDTH are ignored; e.g. 0x1001 and 0x0021 both map to word 1 when MEM_ADDR_WIDTH=5.
- wr_count wraps 255 to 0.
- Reset mid-operation: any in-flight write or read is abandoned next edge.
  - A write already clocked into memory stays.
  - s_rvalid is forced 0 and no response is emitted.
  - Display-pending is cleared.

Decomposition:
- Shared package demo_pkg holds:
  - state encoding (3-bit localparams IDLE..DISP)
  - mode constants MODE_READ=0, MODE_WRITE=1
  - default demo address 16'h1001
  - WRITE_OFFSET=16
- One sub-module, demo_spram: single-port memory, synchronous write, registered read (1-cycle), inferable as block RAM.
  - The responder muxes bus and display addresses onto its port.
  - Any extra latency up to READ_LATENCY is absorbed by the counter.

Test Plan:
- Write then read: write 0xA5 to 0x1001; after s_ready returns, read 0x1001 -> s_rvalid pulses 3 cycles after accept, s_rdata=0xA5, wr_count=1.
- Alias: write 0x3C to 0x0021, read 0x1001 -> 0x3C; read 0x1002 returns its previously written value unchanged.
- Busy drop: assert s_valid read on the cycle after a write accept (s_ready=0) -> no s_rvalid ever appears for it, and wr_count is unchanged by it.
- Display collision: button falling edge with disp_addr=1 on the same cycle as a bus read accept -> bus s_rvalid first; disp_data=memory[1] afterwards; button held low produces no second readback.
- Counter wrap: 256 accepted writes -> wr_count returns to 0; 257th write -> 1.
- Reset mid-read: rst pulsed one cycle during READ -> s_rvalid stays 0, s_ready=1 the cycle after rst deasserts, memory data written earlier still readable.

Source files
------------

// File: rtl/demo_pkg.sv
// demo_pkg: shared state encoding, bus mode codes and demo addresses.
package demo_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DISP  = 3'd4;
  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    RESP  = ST_RESP,
    DISP  = ST_DISP
  } state_t;
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;
  localparam logic [15:0] DEMO_ADDR    = 16'h1001;
  localparam logic [15:0] WRITE_OFFSET = 16'd16;
endpackage

// File: rtl/demo_spram.sv
// demo_spram: single-port RAM, synchronous write, registered 1-cycle read.
module demo_spram #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/demo_slave_responder.sv
// demo_slave_responder: single-beat bus target over local RAM with button readback.
module demo_slave_responder
  import demo_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int READ_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic                      s_mode,
  input  logic [ADDR_WIDTH-1:0]     s_addr,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic                      s_rvalid,
  output logic                      s_ready,
  input  logic                      disp_btn,
  input  logic [MEM_ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0]     disp_data,
  output logic [7:0]                wr_count
);
  localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);
  state_t state;
  logic [1:0] cnt;
  logic btn_prev, disp_pend, btn_edge, mem_we;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr, disp_addr_q, mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic unused_hi;
  assign unused_hi = ^s_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign btn_edge = btn_prev && !disp_btn;
  assign mem_we = !rst && state == IDLE && s_valid && s_mode == MODE_WRITE;
  // IDLE presents the bus address so a write lands on the accept edge; reads use the registered address
  assign mem_addr = state == IDLE ? s_addr[MEM_ADDR_WIDTH-1:0] : rd_addr;
  demo_spram #(.AW(MEM_ADDR_WIDTH), .DW(DATA_WIDTH)) u_ram (
    .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(s_wdata), .rdata(mem_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_ready     <= 1'b1;
      s_rvalid    <= 1'b0;
      s_rdata     <= '0;
      disp_data   <= '0;
      wr_count    <= '0;
      btn_prev    <= 1'b1;
      disp_pend   <= 1'b0;
      disp_addr_q <= '0;
      rd_addr     <= '0;
      cnt         <= '0;
    end else begin
      btn_prev <= disp_btn;
      s_rvalid <= 1'b0;
      if (btn_edge) begin
        disp_pend   <= 1'b1;
        disp_addr_q <= disp_addr;
      end
      case (state)
        IDLE:
          if (s_valid) begin
            s_ready <= 1'b0;
            if (s_mode == MODE_WRITE) begin
              state    <= WRITE;
              wr_count <= wr_count + 8'd1;
            end else begin
              state   <= READ;
              rd_addr <= s_addr[MEM_ADDR_WIDTH-1:0];
              cnt     <= '0;
            end
          end else if (disp_pend) begin
            state   <= DISP;
            s_ready <= 1'b0;
            rd_addr <= disp_addr_q;
            cnt     <= '0;
          end
        READ:
          if (cnt == LAST) begin
            state    <= RESP;
            s_rdata  <= mem_rdata;
            s_rvalid <= 1'b1;
          end else cnt <= cnt + 2'd1;
        DISP:
          if (cnt == LAST) begin
            state     <= IDLE;
            s_ready   <= 1'b1;
            disp_data <= mem_rdata;
            disp_pend <= btn_edge;
          end else cnt <= cnt + 2'd1;
        default: begin
          state   <= IDLE;
          s_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
